// File: rtl/multicon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multicon_pkg
//  Purpose  : Shared types and helpers for the multicon register-port arbiter.
//             Holds the sequencer state encoding and the sizing function for
//             the read-latency wait counter.
//  Revision : 1.0 - initial release
// ============================================================================
package multicon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // The counter must hold the value RD_LATENCY itself.
   function automatic int cnt_width(input int rd_latency);
      return $clog2(rd_latency + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/multicon_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicon_reg_arbiter_if
//  Purpose  : Requester-side command/response bundle plus the shared 64-bit
//             register-port towards the target.
//  Ports    : i_req/i_we/i_addr/i_be/i_wdata  packed per-requester commands
//             o_gnt/o_rvalid/o_rdata          per-requester grant/completion
//             o_reg_*                         target access strobe + command
//             i_reg_rdata                     target read data
//  Modports : slave  - the arbiter
//             master - requesters and target together
//  Revision : 1.0 - initial release
// ============================================================================
interface multicon_reg_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32
);
   logic [NUM_REQ-1:0]            i_req;
   logic [NUM_REQ-1:0]            i_we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr;
   logic [NUM_REQ*8-1:0]          i_be;
   logic [NUM_REQ*64-1:0]         i_wdata;
   logic [NUM_REQ-1:0]            o_gnt;
   logic [NUM_REQ-1:0]            o_rvalid;
   logic [63:0]                   o_rdata;
   logic                          o_reg_req;
   logic                          o_reg_we;
   logic [ADDR_WIDTH-1:0]         o_reg_addr;
   logic [7:0]                    o_reg_be;
   logic [63:0]                   o_reg_wdata;
   logic [63:0]                   i_reg_rdata;

   modport slave (
      input  i_req, i_we, i_addr, i_be, i_wdata, i_reg_rdata,
      output o_gnt, o_rvalid, o_rdata,
             o_reg_req, o_reg_we, o_reg_addr, o_reg_be, o_reg_wdata
   );

   modport master (
      output i_req, i_we, i_addr, i_be, i_wdata, i_reg_rdata,
      input  o_gnt, o_rvalid, o_rdata,
             o_reg_req, o_reg_we, o_reg_addr, o_reg_be, o_reg_wdata
   );
endinterface
`default_nettype wire

// File: rtl/multicon_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : multicon_rr_pick
//  Purpose  : Combinational round-robin selector. Returns the first set
//             request bit at or after ptr, wrapping modulo NUM_REQ.
//  Ports    : req   - request vector
//             ptr   - highest-priority index
//             pick  - one-hot winner (zero when no request)
//             valid - at least one request present
//  Revision : 1.0 - initial release
// ============================================================================
module multicon_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic               valid
);

   function automatic int wrap_add(input logic [PTR_W-1:0] base, input int offs);
      int sum;
      sum = int'(base) + offs;
      return (sum >= NUM_REQ) ? sum - NUM_REQ : sum;
   endfunction

   logic found;

   // Walk priority order k = 0..NUM_REQ-1; only constant indices are used
   // on the vectors, the position match is done arithmetically.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (wrap_add(ptr, k) == j)) begin
               pick[j] = 1'b1;
               found   = 1'b1;
            end
         end
      end
   end

   assign valid = found;

endmodule
`default_nettype wire

// File: rtl/multicon_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : multicon_reg_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one 64-bit register port
//             between NUM_REQ requesters. One access in flight at a time:
//             IDLE -> ISSUE (strobe + grant) -> WAIT (RD_LATENCY cycles)
//             -> RESP (completion pulse) -> IDLE.
//  Ports    : clk   - clock
//             rst_n - synchronous active-low reset
//             bus   - slave modport of multicon_reg_arbiter_if
//  Revision : 1.0 - initial release
// ============================================================================
module multicon_reg_arbiter
   import multicon_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multicon_reg_arbiter_if.slave bus
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = cnt_width(RD_LATENCY);

   state_t                  state, state_nxt;
   logic [PTR_W-1:0]        ptr, ptr_nxt;
   logic [NUM_REQ-1:0]      owner;
   logic [CNT_W-1:0]        cnt;
   logic                    reg_we;
   logic [ADDR_WIDTH-1:0]   reg_addr;
   logic [7:0]              reg_be;
   logic [63:0]             reg_wdata;
   logic [63:0]             rdata;

   logic [NUM_REQ-1:0]      pick;
   logic                    pick_valid;
   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [7:0]              sel_be;
   logic [63:0]             sel_wdata;
   logic [NUM_REQ-1:0]      gnt;
   logic [NUM_REQ-1:0]      rvalid;
   logic                    reg_req;

   multicon_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req   (bus.i_req),
      .ptr   (ptr),
      .pick  (pick),
      .valid (pick_valid)
   );

   // One-hot AND-OR mux of the winning requester's command fields.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_be    = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) begin
            sel_we    = sel_we    | bus.i_we[i];
            sel_addr  = sel_addr  | bus.i_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_be    = sel_be    | bus.i_be[i*8 +: 8];
            sel_wdata = sel_wdata | bus.i_wdata[i*64 +: 64];
         end
      end
   end

   // Priority moves to the requester just after the one served.
   always_comb begin
      ptr_nxt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner[i]) begin
            ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt       = '0;
      rvalid    = '0;
      reg_req   = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            reg_req   = 1'b1;
            gnt       = owner;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) state_nxt = RESP;
         end
         RESP: begin
            rvalid    = owner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         owner     <= '0;
         cnt       <= '0;
         reg_we    <= 1'b0;
         reg_addr  <= '0;
         reg_be    <= '0;
         reg_wdata <= '0;
         rdata     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_valid) begin
                  owner     <= pick;
                  reg_we    <= sel_we;
                  reg_addr  <= sel_addr;
                  reg_be    <= sel_be;
                  reg_wdata <= sel_wdata;
               end
            end
            ISSUE: cnt <= CNT_W'(RD_LATENCY);
            WAIT: begin
               // Sample exactly RD_LATENCY cycles after the strobe cycle.
               if (cnt == CNT_W'(1)) begin
                  rdata <= bus.i_reg_rdata;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: ptr <= ptr_nxt;
            default: ;
         endcase
      end
   end

   assign bus.o_gnt       = gnt;
   assign bus.o_rvalid    = rvalid;
   assign bus.o_rdata     = rdata;
   assign bus.o_reg_req   = reg_req;
   assign bus.o_reg_we    = reg_we & reg_req;
   assign bus.o_reg_addr  = reg_addr;
   assign bus.o_reg_be    = reg_be;
   assign bus.o_reg_wdata = reg_wdata;

endmodule
`default_nettype wire
